// File: rtl/life_counter.sv
// Player lives bookkeeping: loss, bonus, frame-counted respawn delay, game over.
// Drives the life bus and ball enable/reset strobes for the playfield.
module life_counter #(
   parameter int INITIAL_LIFE   = 3,
   parameter int MAX_LIFE       = 9,
   parameter int RESPAWN_FRAMES = 60
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       ballLost,
   input  logic       extraLife,
   input  logic       newGame,
   output logic [3:0] life,
   output logic       gameOver,
   output logic       ballEnable,
   output logic       ballReset
);

   localparam logic [3:0] INIT_L = 4'(INITIAL_LIFE);
   localparam logic [3:0] MAX_L  = 4'(MAX_LIFE);
   localparam logic [7:0] LAST_F = 8'(RESPAWN_FRAMES - 1);

   typedef enum logic [1:0] {
      PLAYING,
      RESPAWN,
      GAME_OVER
   } state_t;

   state_t     state;
   logic [7:0] frameCnt;
   logic [3:0] lifeInc;

   assign lifeInc = (life >= MAX_L) ? life : life + 4'd1;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= PLAYING;
         life       <= INIT_L;
         frameCnt   <= 8'd0;
         gameOver   <= 1'b0;
         ballEnable <= 1'b1;
         ballReset  <= 1'b0;
      end else begin
         ballReset <= 1'b0;
         if (newGame) begin
            state      <= RESPAWN;
            life       <= INIT_L;
            frameCnt   <= 8'd0;
            gameOver   <= 1'b0;
            ballEnable <= 1'b0;
         end else begin
            case (state)
               PLAYING: begin
                  if (ballLost) begin
                     frameCnt   <= 8'd0;
                     ballEnable <= 1'b0;
                     // a bonus on the same cycle pays for the lost ball
                     if (extraLife) begin
                        state <= RESPAWN;
                     end else if (life > 4'd1) begin
                        life  <= life - 4'd1;
                        state <= RESPAWN;
                     end else begin
                        life     <= 4'd0;
                        state    <= GAME_OVER;
                        gameOver <= 1'b1;
                     end
                  end else if (extraLife) begin
                     life <= lifeInc;
                  end
               end
               RESPAWN: begin
                  if (extraLife)
                     life <= lifeInc;
                  if (startOfFrame) begin
                     if (frameCnt == LAST_F) begin
                        frameCnt   <= 8'd0;
                        state      <= PLAYING;
                        ballEnable <= 1'b1;
                        ballReset  <= 1'b1;
                     end else begin
                        frameCnt <= frameCnt + 8'd1;
                     end
                  end
               end
               default: begin
                  life <= 4'd0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_life_counter.sv
// Directed and random stimulus for life_counter against a lives/frames-left
// reference model.
module tb_life_counter;

   localparam int INIT = 3;
   localparam int MAXL = 9;
   localparam int RF   = 4;

   logic       clk = 1'b0;
   logic       resetN = 1'b1;
   logic       startOfFrame = 1'b0;
   logic       ballLost = 1'b0;
   logic       extraLife = 1'b0;
   logic       newGame = 1'b0;
   logic [3:0] life;
   logic       gameOver;
   logic       ballEnable;
   logic       ballReset;

   int checks = 0;
   int errors = 0;

   // model: frames still to wait (0 = ball in play), game-over flag
   int lives = INIT;
   int left  = 0;
   bit over  = 0;
   bit pulse = 0;

   life_counter #(
      .INITIAL_LIFE(INIT),
      .MAX_LIFE(MAXL),
      .RESPAWN_FRAMES(RF)
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .startOfFrame(startOfFrame),
      .ballLost(ballLost),
      .extraLife(extraLife),
      .newGame(newGame),
      .life(life),
      .gameOver(gameOver),
      .ballEnable(ballEnable),
      .ballReset(ballReset)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".life"}, 8'(life), 8'(lives));
      chk({tag, ".gameOver"}, 8'(gameOver), 8'(over));
      chk({tag, ".ballEnable"}, 8'(ballEnable), 8'(!over && left == 0));
      chk({tag, ".ballReset"}, 8'(ballReset), 8'(pulse));
   endtask

   task automatic model(input bit s, input bit b, input bit e, input bit n);
      pulse = 0;
      if (n) begin
         lives = INIT;
         left  = RF;
         over  = 0;
      end else if (over) begin
         lives = 0;
      end else if (left == 0) begin
         if (b) begin
            if (e) left = RF;
            else if (lives > 1) begin
               lives--;
               left = RF;
            end else begin
               lives = 0;
               over  = 1;
            end
         end else if (e) begin
            lives = (lives + 1 > MAXL) ? MAXL : lives + 1;
         end
      end else begin
         if (e) lives = (lives + 1 > MAXL) ? MAXL : lives + 1;
         if (s) begin
            left--;
            if (left == 0) pulse = 1;
         end
      end
   endtask

   task automatic step(input string tag, input bit s, input bit b,
                       input bit e, input bit n);
      startOfFrame = s;
      ballLost     = b;
      extraLife    = e;
      newGame      = n;
      @(posedge clk);
      model(s, b, e, n);
      #1;
      startOfFrame = 1'b0;
      ballLost     = 1'b0;
      extraLife    = 1'b0;
      newGame      = 1'b0;
      chk_all(tag);
   endtask

   task automatic finish_respawn(input string tag);
      for (int i = 0; i < RF; i++) begin
         step(tag, 1, 0, 0, 0);
         step(tag, 0, 0, 0, 0);
      end
   endtask

   initial begin
      #1 resetN = 1'b0;
      #2;
      chk_all("rst_async");
      repeat (2) @(posedge clk);
      #2;
      chk_all("rst_held");
      resetN = 1'b1;
      @(posedge clk);
      #1;
      chk_all("rst_released");

      step("loss", 0, 1, 0, 0);
      chk("loss.life2", 8'(life), 8'd2);
      step("lost_in_respawn", 0, 1, 0, 0);
      step("lost_in_respawn2", 1, 1, 0, 0);
      for (int i = 1; i < RF; i++) begin
         step("resp_frame", 1, 0, 0, 0);
         step("resp_gap", 0, 0, 0, 0);
      end
      chk("resp.en", 8'(ballEnable), 8'd1);

      step("loss2", 0, 1, 0, 0);
      finish_respawn("resp2");
      step("loss3", 1, 1, 0, 0);
      chk("over.flag", 8'(gameOver), 8'd1);
      step("over_extra", 0, 0, 1, 0);
      step("over_lost", 0, 1, 0, 0);
      step("over_sof", 1, 0, 0, 0);
      step("newgame", 0, 0, 0, 1);
      chk("newgame.life", 8'(life), 8'd3);
      step("ng_restart", 1, 0, 0, 0);
      step("ng_again", 0, 0, 0, 1);
      finish_respawn("resp3");

      for (int i = 0; i < 10; i++) step("sat", 0, 0, 1, 0);
      chk("sat.life9", 8'(life), 8'd9);

      step("ng2", 0, 0, 0, 1);
      finish_respawn("resp4");
      step("to2", 0, 1, 0, 0);
      finish_respawn("resp5");
      step("to1", 0, 1, 0, 0);
      finish_respawn("resp6");
      step("lost_extra_at1", 0, 1, 1, 0);
      chk("le.life1", 8'(life), 8'd1);
      finish_respawn("resp7");
      step("lost_ng_at1", 0, 1, 0, 1);
      step("mid_resp", 1, 0, 0, 0);

      #3 resetN = 1'b0;
      lives = INIT;
      left  = 0;
      over  = 0;
      pulse = 0;
      #1;
      chk_all("rst_mid_respawn");
      repeat (2) @(posedge clk);
      #3 resetN = 1'b1;
      for (int i = 0; i < 3; i++) step("post_rst", 1, 0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         step("rand",
              ($urandom_range(2) == 0),
              ($urandom_range(7) == 0),
              ($urandom_range(9) == 0),
              ($urandom_range(59) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
